// File: rtl/seq_array_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock, MSB first.
// Valid/ready on both sides; a single operation is in flight between acceptance and consumption.
module seq_array_div #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_ITER = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [2*N-1:0] work_q, work_d;
  logic [N-1:0]   divisor_q, divisor_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     trial;
  logic [N-1:0]   diff;
  logic           fits;

  // A partial remainder below the divisor always fits in N bits, so the
  // wrap-around N-bit difference is exact whenever it is used.
  always_comb begin
    trial = {rem_q, work_q[2*N-1]};
    fits  = (trial >= {1'b0, divisor_q});
    diff  = trial[N-1:0] - divisor_q;
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          divisor_d = divisor;
          rem_d     = '0;
          cnt_d     = '0;
          if (divisor == '0) begin
            work_d  = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            work_d  = dividend;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = fits ? diff : trial[N-1:0];
        work_d = {work_q[2*N-2:0], fits};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      dbz_q     <= dbz_d;
    end
  end

  assign quotient    = work_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_array_div.sv
// Scoreboard bench for seq_array_div (N=4): the driver queues expected results,
// an independent monitor pops and compares each result as it is consumed.
module tb_seq_array_div;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  exp_t sb[$];

  seq_array_div #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.dbz = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r, input logic dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    return e;
  endfunction

  // Monitor: compares every consumed result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected result: got q=%0d r=%0d dbz=%0d with empty scoreboard",
                 quotient, remainder, div_by_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result quotient", 32'(quotient), 32'(e.q));
        chk("result remainder", 32'(remainder), 32'(e.r));
        chk("result div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        $display("[TB] result q=%0d r=%0d dbz=%0d (expected q=%0d r=%0d dbz=%0d)",
                 quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
    end
  end

  // Issue one operation; returns at #1 after the accepting edge with that edge's cycle number.
  task automatic send(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                      input bit push, output int acc);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL in_ready timeout: got 0 required 1 for %0d/%0d", a, b);
      acc = -1;
      return;
    end
    in_valid = 1'b1; dividend = a; divisor = b;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    acc = cyc_cnt;
    in_valid = 1'b0;
    dividend = 8'($urandom); divisor = 4'($urandom);
  endtask

  // Call right after send(): cycles from acceptance until out_valid (accept cycle counts as 1).
  task automatic latency(input string name, input int exp_lat);
    int c;
    c = 1;
    while (!out_valid && c < 50) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 32'(c), 32'(exp_lat));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc, prev_acc, hi_cnt;
    logic [3:0] prev_b;
    logic [7:0] ra;
    logic [3:0] rb;
    logic [7:0] corner_a [10];
    logic [3:0] corner_b [10];
    corner_a = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd200, 8'd15, 8'd14, 8'd128};
    corner_b = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(8'd200, 4'd7, mk(8'd28, 4'd4, 1'b0), 1'b1, acc);
    latency("latency 200/7", 9);
    send(8'd143, 4'd11, mk(8'd13, 4'd0, 1'b0), 1'b1, acc);
    send(8'd255, 4'd1, mk(8'd255, 4'd0, 1'b0), 1'b1, acc);
    send(8'd7, 4'd9, mk(8'd0, 4'd7, 1'b0), 1'b1, acc);
    send(8'd0, 4'd5, mk(8'd0, 4'd0, 1'b0), 1'b1, acc);
    send(8'd37, 4'd0, mk(8'd255, 4'd0, 1'b1), 1'b1, acc);
    latency("latency 37/0", 1);
    drain();

    // Stalled sink: result must hold, in_valid pulses must be ignored.
    out_ready = 1'b0;
    send(8'd100, 4'd3, mk(8'd33, 4'd1, 1'b0), 1'b1, acc);
    latency("latency 100/3", 9);
    for (int k = 0; k < 5; k++) begin
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall quotient", 32'(quotient), 32'd33);
      chk("stall remainder", 32'(remainder), 32'd1);
      chk("stall div_by_zero", 32'(div_by_zero), 32'd0);
      in_valid = (k % 2 == 0); dividend = 8'd9; divisor = 4'd2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during CALC iteration 4 discards the in-flight 200/7.
    send(8'd200, 4'd7, mk(8'd28, 4'd4, 1'b0), 1'b0, acc);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-calc reset in_ready", 32'(in_ready), 32'd1);
    chk("mid-calc reset out_valid", 32'(out_valid), 32'd0);
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) hi_cnt++;
      @(posedge clk); #1;
    end
    chk("discarded op produced no output", 32'(hi_cnt), 32'd0);
    send(8'd50, 4'd6, mk(8'd8, 4'd2, 1'b0), 1'b1, acc);
    drain();

    // Back-to-back: corner pairs first, then random ones.
    prev_acc = -1;
    prev_b = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      if (i < 10) begin
        ra = corner_a[i]; rb = corner_b[i];
      end else begin
        ra = 8'($urandom); rb = 4'($urandom_range(0, 15));
      end
      send(ra, rb, model(ra, rb), 1'b1, acc);
      if (prev_acc >= 0 && acc >= 0)
        chk("back-to-back spacing", 32'(acc - prev_acc), (prev_b != 4'd0) ? 32'd10 : 32'd2);
      prev_acc = acc;
      prev_b = rb;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no completion, required completion before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
